// File: rtl/game_pkg.sv
// Shared types and helpers for the game controllers: match state encoding,
// team limits and a constant-friendly ceil(log2) for sizing counters.
package game_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RUN,
      PAUSED,
      HOLD,
      SUDDEN,
      OVER
   } state_e;

   localparam int MAX_TEAMS = 8;

   // Number of bits needed to hold the values 0 .. value-1.
   function automatic int clog2(input int value);
      int bits;
      int rem;
      bits = 0;
      rem  = value - 1;
      while (rem > 0) begin
         bits = bits + 1;
         rem  = rem >> 1;
      end
      return bits;
   endfunction

endpackage

// File: rtl/tick_divider.sv
// Enable-gated modulo counter that pulses tick_o on the cycle it wraps,
// i.e. once every TICKS_PER_SEC enabled cycles.
module tick_divider
   import game_pkg::*;
#(
   parameter int TICKS_PER_SEC = 50000000
) (
   input  logic clk,
   input  logic rst,
   input  logic en_i,
   output logic tick_o
);

   localparam int CNT_W = (TICKS_PER_SEC > 1) ? clog2(TICKS_PER_SEC) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TICKS_PER_SEC - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // The count only moves while enabled, so a frozen timer resumes mid-second.
   always_comb begin
      cnt_d  = cnt_q;
      tick_o = 1'b0;
      if (en_i) begin
         if (cnt_q == LAST) begin
            cnt_d  = '0;
            tick_o = 1'b1;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/match_controller.sv
// Match timer and scoreboard: countdown, per-team saturating scores, win limit,
// post-goal hold and optional sudden-death overtime.
module match_controller
   import game_pkg::*;
#(
   parameter int NUM_TEAMS     = 2,
   parameter int SCORE_W       = 4,
   parameter int TIME_W        = 8,
   parameter int MATCH_SECONDS = 180,
   parameter int TICKS_PER_SEC = 50000000,
   parameter int WIN_SCORE     = 10,
   parameter int HOLD_CYCLES   = 25000000,
   parameter int OVERTIME_EN   = 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start_i,
   input  logic                         pause_i,
   input  logic [NUM_TEAMS-1:0]         goal_i,
   output logic                         game_on_o,
   output logic                         game_over_o,
   output logic                         in_hold_o,
   output logic                         overtime_o,
   output logic                         sec_tick_o,
   output logic [TIME_W-1:0]            time_left_o,
   output logic [NUM_TEAMS*SCORE_W-1:0] scores_o,
   output logic [2:0]                   winner_o,
   output logic                         winner_valid_o
);

   localparam int SCORES_W  = NUM_TEAMS * SCORE_W;
   localparam int WIN_IDX_W = clog2(MAX_TEAMS);
   localparam int HOLD_W    = (HOLD_CYCLES > 1) ? clog2(HOLD_CYCLES) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LOAD =
      HOLD_W'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);

   state_e              state_q, state_d;
   state_e              ret_q, ret_d;
   logic [TIME_W-1:0]   time_q, time_d;
   logic [SCORES_W-1:0] scores_q, scores_d;
   logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
   logic                on_q, on_d;
   logic                over_q, over_d;
   logic                in_hold_q, in_hold_d;
   logic                ot_q, ot_d;
   logic                tick_q, tick_d;

   logic                tick_en;
   logic                sec_pulse;
   logic                goal_any;
   logic [SCORES_W-1:0] bumped;
   logic                bumped_unique;
   logic                bumped_limit;

   function automatic logic [SCORES_W-1:0] add_goals(input logic [SCORES_W-1:0] s,
                                                     input logic [NUM_TEAMS-1:0] g);
      logic [SCORES_W-1:0] r;
      logic [SCORE_W-1:0]  v;
      r = s;
      for (int i = 0; i < NUM_TEAMS; i++) begin
         v = s[i*SCORE_W +: SCORE_W];
         if (g[i] && (v != '1)) begin
            v = v + 1'b1;
         end
         r[i*SCORE_W +: SCORE_W] = v;
      end
      return r;
   endfunction

   function automatic logic is_unique(input logic [SCORES_W-1:0] s);
      logic [SCORE_W-1:0] best;
      logic               uniq;
      best = s[SCORE_W-1:0];
      uniq = 1'b1;
      for (int i = 1; i < NUM_TEAMS; i++) begin
         if (s[i*SCORE_W +: SCORE_W] > best) begin
            best = s[i*SCORE_W +: SCORE_W];
            uniq = 1'b1;
         end else if (s[i*SCORE_W +: SCORE_W] == best) begin
            uniq = 1'b0;
         end
      end
      return uniq;
   endfunction

   // Strict greater-than keeps the lowest index on ties.
   function automatic logic [WIN_IDX_W-1:0] lead_idx(input logic [SCORES_W-1:0] s);
      logic [SCORE_W-1:0]   best;
      logic [WIN_IDX_W-1:0] idx;
      best = s[SCORE_W-1:0];
      idx  = '0;
      for (int i = 1; i < NUM_TEAMS; i++) begin
         if (s[i*SCORE_W +: SCORE_W] > best) begin
            best = s[i*SCORE_W +: SCORE_W];
            idx  = WIN_IDX_W'(i);
         end
      end
      return idx;
   endfunction

   function automatic logic hits_limit(input logic [SCORES_W-1:0] s);
      logic hit;
      hit = 1'b0;
      if (WIN_SCORE != 0) begin
         for (int i = 0; i < NUM_TEAMS; i++) begin
            if (int'(s[i*SCORE_W +: SCORE_W]) >= WIN_SCORE) begin
               hit = 1'b1;
            end
         end
      end
      return hit;
   endfunction

   assign tick_en       = (state_q == RUN) && (time_q != '0);
   assign goal_any      = |goal_i;
   assign bumped        = add_goals(scores_q, goal_i);
   assign bumped_unique = is_unique(bumped);
   assign bumped_limit  = hits_limit(bumped);

   tick_divider #(
      .TICKS_PER_SEC(TICKS_PER_SEC)
   ) u_sec_div (
      .clk   (clk),
      .rst   (rst),
      .en_i  (tick_en),
      .tick_o(sec_pulse)
   );

   // Goals are folded into the score before the expiry decision, so a last-instant
   // goal can break a draw; the win limit always overrides the post-goal hold.
   always_comb begin
      state_d    = state_q;
      ret_d      = ret_q;
      time_d     = time_q;
      scores_d   = scores_q;
      hold_cnt_d = hold_cnt_q;
      tick_d     = 1'b0;

      if (sec_pulse) begin
         time_d = time_q - 1'b1;
         tick_d = 1'b1;
      end

      case (state_q)
         IDLE: begin
            if (start_i) begin
               state_d = RUN;
            end
         end
         RUN: begin
            if (time_q == '0) begin
               scores_d = bumped;
               if (bumped_limit || bumped_unique || (OVERTIME_EN == 0)) begin
                  state_d = OVER;
               end else begin
                  state_d = SUDDEN;
               end
            end else if (goal_any) begin
               scores_d = bumped;
               if (bumped_limit) begin
                  state_d = OVER;
               end else if (HOLD_CYCLES != 0) begin
                  state_d    = HOLD;
                  ret_d      = RUN;
                  hold_cnt_d = HOLD_LOAD;
               end
            end else if (pause_i) begin
               state_d = PAUSED;
            end
         end
         PAUSED: begin
            if (pause_i) begin
               state_d = RUN;
            end
         end
         HOLD: begin
            if (hold_cnt_q == '0) begin
               state_d = ret_q;
            end else begin
               hold_cnt_d = hold_cnt_q - 1'b1;
            end
         end
         SUDDEN: begin
            if (goal_any) begin
               scores_d = bumped;
               if (bumped_limit || bumped_unique) begin
                  state_d = OVER;
               end else if (HOLD_CYCLES != 0) begin
                  state_d    = HOLD;
                  ret_d      = SUDDEN;
                  hold_cnt_d = HOLD_LOAD;
               end
            end
         end
         OVER: begin
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      on_d      = (state_d == RUN) || (state_d == SUDDEN);
      over_d    = (state_d == OVER);
      in_hold_d = (state_d == HOLD);
      ot_d      = (state_d == SUDDEN) ||
                  ((state_d == OVER) && ((state_q == SUDDEN) || ot_q));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         ret_q      <= RUN;
         time_q     <= TIME_W'(MATCH_SECONDS);
         scores_q   <= '0;
         hold_cnt_q <= '0;
         on_q       <= 1'b0;
         over_q     <= 1'b0;
         in_hold_q  <= 1'b0;
         ot_q       <= 1'b0;
         tick_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         ret_q      <= ret_d;
         time_q     <= time_d;
         scores_q   <= scores_d;
         hold_cnt_q <= hold_cnt_d;
         on_q       <= on_d;
         over_q     <= over_d;
         in_hold_q  <= in_hold_d;
         ot_q       <= ot_d;
         tick_q     <= tick_d;
      end
   end

   assign game_on_o      = on_q;
   assign game_over_o    = over_q;
   assign in_hold_o      = in_hold_q;
   assign overtime_o     = ot_q;
   assign sec_tick_o     = tick_q;
   assign time_left_o    = time_q;
   assign scores_o       = scores_q;
   assign winner_o       = lead_idx(scores_q);
   assign winner_valid_o = (state_q == OVER) && is_unique(scores_q);

endmodule

// File: tb/tb_match_controller.sv
// Self-checking bench for match_controller: table-driven vectors through a
// scoreboard queue, plus hand-written overtime, expiry, reset and saturation cases.
module tb_match_controller;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0;
   logic       pause = 1'b0;
   logic [1:0] goal = 2'b00;
   logic       cStart = 1'b0;
   logic [1:0] cGoal = 2'b00;

   logic       aOn, aOver, aHold, aOt, aTick, aWv;
   logic [7:0] aTime, aScores;
   logic [2:0] aWin;
   logic       bOn, bOver, bHold, bOt, bTick, bWv;
   logic [7:0] bTime, bScores;
   logic [2:0] bWin;
   logic       cOn, cOver, cHold, cOt, cTick, cWv;
   logic [7:0] cTime;
   logic [3:0] cScores;
   logic [2:0] cWin;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        start;
      logic        pause;
      logic [1:0]  goal;
      logic [24:0] exp;
   } vec_t;

   vec_t tbl[$];
   vec_t expQ[$];

   always #5 clk = ~clk;

   match_controller #(
      .NUM_TEAMS(2), .SCORE_W(4), .TIME_W(8), .MATCH_SECONDS(3), .TICKS_PER_SEC(4),
      .WIN_SCORE(3), .HOLD_CYCLES(2), .OVERTIME_EN(0)
   ) dutA (
      .clk(clk), .rst(rst), .start_i(start), .pause_i(pause), .goal_i(goal),
      .game_on_o(aOn), .game_over_o(aOver), .in_hold_o(aHold), .overtime_o(aOt),
      .sec_tick_o(aTick), .time_left_o(aTime), .scores_o(aScores),
      .winner_o(aWin), .winner_valid_o(aWv)
   );

   match_controller #(
      .NUM_TEAMS(2), .SCORE_W(4), .TIME_W(8), .MATCH_SECONDS(3), .TICKS_PER_SEC(4),
      .WIN_SCORE(3), .HOLD_CYCLES(2), .OVERTIME_EN(1)
   ) dutB (
      .clk(clk), .rst(rst), .start_i(start), .pause_i(pause), .goal_i(goal),
      .game_on_o(bOn), .game_over_o(bOver), .in_hold_o(bHold), .overtime_o(bOt),
      .sec_tick_o(bTick), .time_left_o(bTime), .scores_o(bScores),
      .winner_o(bWin), .winner_valid_o(bWv)
   );

   match_controller #(
      .NUM_TEAMS(2), .SCORE_W(2), .TIME_W(8), .MATCH_SECONDS(3), .TICKS_PER_SEC(4),
      .WIN_SCORE(0), .HOLD_CYCLES(2), .OVERTIME_EN(0)
   ) dutC (
      .clk(clk), .rst(rst), .start_i(cStart), .pause_i(1'b0), .goal_i(cGoal),
      .game_on_o(cOn), .game_over_o(cOver), .in_hold_o(cHold), .overtime_o(cOt),
      .sec_tick_o(cTick), .time_left_o(cTime), .scores_o(cScores),
      .winner_o(cWin), .winner_valid_o(cWv)
   );

   // Expected row for dutA: {on, over, hold, overtime, tick, time, s0, s1, wv, winner}.
   function automatic vec_t mk(input logic st, input logic pa, input logic [1:0] g,
                               input logic on, input logic ov, input logic hd,
                               input logic ot, input logic tk, input int t,
                               input int s0, input int s1, input logic wv, input int w);
      vec_t v;
      v.start = st;
      v.pause = pa;
      v.goal  = g;
      v.exp   = {on, ov, hd, ot, tk, 8'(t), 4'(s0), 4'(s1), wv, 3'(w)};
      return v;
   endfunction

   task automatic applyStimulus(input vec_t v);
      @(negedge clk);
      start = v.start;
      pause = v.pause;
      goal  = v.goal;
      expQ.push_back(v);
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input int idx);
      vec_t        e;
      logic [24:0] act;
      e   = expQ.pop_front();
      act = {aOn, aOver, aHold, aOt, aTick, aTime, aScores[3:0], aScores[7:4], aWv, aWin};
      checks++;
      if (act !== e.exp) begin
         errors++;
         $display("[TB] FAIL %s[%0d] got %h expected %h", name, idx, act, e.exp);
      end
   endtask

   task automatic runTable(input string name);
      for (int i = 0; i < tbl.size(); i++) begin
         applyStimulus(tbl[i]);
         checkOutput(name, i);
      end
      tbl.delete();
   endtask

   task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic stepCycle(input logic st, input logic pa, input logic [1:0] g);
      @(negedge clk);
      start = st;
      pause = pa;
      goal  = g;
      @(posedge clk);
      #1;
   endtask

   task automatic stepC(input logic st, input logic [1:0] g);
      @(negedge clk);
      cStart = st;
      cGoal  = g;
      @(posedge clk);
      #1;
   endtask

   task automatic doReset();
      @(negedge clk);
      rst    = 1'b1;
      start  = 1'b0;
      pause  = 1'b0;
      goal   = 2'b00;
      cStart = 1'b0;
      cGoal  = 2'b00;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog expired before the end of the test");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      doReset();
      checkValue("reset_time", 32'(aTime), 32'd3);
      checkValue("reset_on", 32'(aOn), 32'd0);
      checkValue("reset_over", 32'(aOver), 32'd0);
      checkValue("reset_scores", 32'(aScores), 32'd0);
      checkValue("reset_wv", 32'(aWv), 32'd0);
      checkValue("reset_tick", 32'(aTick), 32'd0);

      // Plain countdown to a 0:0 draw.
      tbl.push_back(mk(1, 0, 2'b00, 1, 0, 0, 0, 0, 3, 0, 0, 0, 0));
      for (int sec = 3; sec >= 1; sec--) begin
         for (int c = 0; c < 3; c++) begin
            tbl.push_back(mk(0, 0, 2'b00, 1, 0, 0, 0, 0, sec, 0, 0, 0, 0));
         end
         tbl.push_back(mk(0, 0, 2'b00, 1, 0, 0, 0, 1, sec - 1, 0, 0, 0, 0));
      end
      tbl.push_back(mk(0, 0, 2'b00, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(1, 0, 2'b00, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
      runTable("countdown");

      checkValue("sudden_on", 32'(bOn), 32'd1);
      checkValue("sudden_ot", 32'(bOt), 32'd1);
      checkValue("sudden_over", 32'(bOver), 32'd0);
      stepCycle(0, 0, 2'b11);
      checkValue("sudden_draw_hold", 32'(bHold), 32'd1);
      checkValue("sudden_draw_scores", 32'(bScores), 32'h11);
      stepCycle(0, 0, 2'b00);
      stepCycle(0, 0, 2'b00);
      checkValue("sudden_back_on", 32'(bOn), 32'd1);
      checkValue("sudden_back_ot", 32'(bOt), 32'd1);
      stepCycle(0, 0, 2'b10);
      checkValue("sudden_end_over", 32'(bOver), 32'd1);
      checkValue("sudden_end_ot", 32'(bOt), 32'd1);
      checkValue("sudden_end_wv", 32'(bWv), 32'd1);
      checkValue("sudden_end_winner", 32'(bWin), 32'd1);
      checkValue("over_ignores_goals", 32'(aScores), 32'd0);

      // Goal hold, ignored goals, then pause freezing the timer.
      doReset();
      tbl.push_back(mk(1, 0, 2'b00, 1, 0, 0, 0, 0, 3, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 2'b01, 0, 0, 1, 0, 0, 3, 1, 0, 0, 0));
      tbl.push_back(mk(0, 0, 2'b10, 0, 0, 1, 0, 0, 3, 1, 0, 0, 0));
      tbl.push_back(mk(0, 0, 2'b00, 1, 0, 0, 0, 0, 3, 1, 0, 0, 0));
      tbl.push_back(mk(0, 0, 2'b00, 1, 0, 0, 0, 0, 3, 1, 0, 0, 0));
      tbl.push_back(mk(0, 0, 2'b00, 1, 0, 0, 0, 0, 3, 1, 0, 0, 0));
      tbl.push_back(mk(0, 0, 2'b00, 1, 0, 0, 0, 1, 2, 1, 0, 0, 0));
      tbl.push_back(mk(0, 1, 2'b00, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0));
      tbl.push_back(mk(0, 0, 2'b00, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0));
      tbl.push_back(mk(0, 0, 2'b01, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0));
      tbl.push_back(mk(0, 0, 2'b00, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0));
      tbl.push_back(mk(0, 0, 2'b00, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0));
      tbl.push_back(mk(0, 1, 2'b00, 1, 0, 0, 0, 0, 2, 1, 0, 0, 0));
      tbl.push_back(mk(0, 0, 2'b00, 1, 0, 0, 0, 0, 2, 1, 0, 0, 0));
      tbl.push_back(mk(0, 0, 2'b00, 1, 0, 0, 0, 0, 2, 1, 0, 0, 0));
      tbl.push_back(mk(0, 0, 2'b00, 1, 0, 0, 0, 1, 1, 1, 0, 0, 0));
      runTable("hold_pause");

      // Team 1 reaches the win limit after two holds.
      doReset();
      tbl.push_back(mk(1, 0, 2'b00, 1, 0, 0, 0, 0, 3, 0, 0, 0, 0));
      for (int k = 1; k <= 2; k++) begin
         tbl.push_back(mk(0, 0, 2'b10, 0, 0, 1, 0, 0, 3, 0, k, 0, 1));
         tbl.push_back(mk(0, 0, 2'b00, 0, 0, 1, 0, 0, 3, 0, k, 0, 1));
         tbl.push_back(mk(0, 0, 2'b00, 1, 0, 0, 0, 0, 3, 0, k, 0, 1));
      end
      tbl.push_back(mk(0, 0, 2'b10, 0, 1, 0, 0, 0, 3, 0, 3, 1, 1));
      tbl.push_back(mk(0, 0, 2'b01, 0, 1, 0, 0, 0, 3, 0, 3, 1, 1));
      tbl.push_back(mk(0, 0, 2'b00, 0, 1, 0, 0, 0, 3, 0, 3, 1, 1));
      tbl.push_back(mk(0, 0, 2'b00, 0, 1, 0, 0, 0, 3, 0, 3, 1, 1));
      runTable("win_limit");

      // Simultaneous goals, one of them alongside a pause that must be dropped.
      doReset();
      tbl.push_back(mk(1, 0, 2'b00, 1, 0, 0, 0, 0, 3, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 2'b11, 0, 0, 1, 0, 0, 3, 1, 1, 0, 0));
      tbl.push_back(mk(0, 0, 2'b00, 0, 0, 1, 0, 0, 3, 1, 1, 0, 0));
      tbl.push_back(mk(0, 0, 2'b00, 1, 0, 0, 0, 0, 3, 1, 1, 0, 0));
      tbl.push_back(mk(0, 1, 2'b11, 0, 0, 1, 0, 0, 3, 2, 2, 0, 0));
      tbl.push_back(mk(0, 0, 2'b00, 0, 0, 1, 0, 0, 3, 2, 2, 0, 0));
      tbl.push_back(mk(0, 0, 2'b00, 1, 0, 0, 0, 0, 3, 2, 2, 0, 0));
      tbl.push_back(mk(0, 0, 2'b11, 0, 1, 0, 0, 0, 3, 3, 3, 0, 0));
      tbl.push_back(mk(0, 0, 2'b00, 0, 1, 0, 0, 0, 3, 3, 3, 0, 0));
      runTable("simultaneous");

      // A goal on the expiry cycle breaks the draw before overtime is considered.
      doReset();
      stepCycle(1, 0, 2'b00);
      for (int i = 0; i < 12; i++) begin
         stepCycle(0, 0, 2'b00);
      end
      checkValue("expiry_time_zero", 32'(aTime), 32'd0);
      checkValue("expiry_still_on", 32'(aOn), 32'd1);
      stepCycle(0, 0, 2'b01);
      checkValue("expiry_goal_over", 32'(aOver), 32'd1);
      checkValue("expiry_goal_wv", 32'(aWv), 32'd1);
      checkValue("expiry_goal_winner", 32'(aWin), 32'd0);
      checkValue("expiry_goal_scores", 32'(aScores), 32'h01);
      checkValue("expiry_goal_b_over", 32'(bOver), 32'd1);
      checkValue("expiry_goal_b_ot", 32'(bOt), 32'd0);
      checkValue("expiry_goal_b_wv", 32'(bWv), 32'd1);

      // Reset asserted between clock edges in the middle of a hold.
      doReset();
      stepCycle(1, 0, 2'b00);
      stepCycle(0, 0, 2'b01);
      checkValue("pre_reset_hold", 32'(aHold), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      checkValue("async_reset_hold", 32'(aHold), 32'd0);
      checkValue("async_reset_on", 32'(aOn), 32'd0);
      checkValue("async_reset_scores", 32'(aScores), 32'd0);
      checkValue("async_reset_time", 32'(aTime), 32'd3);
      @(negedge clk);
      rst = 1'b0;

      // Two-bit scores with no win limit saturate at 3.
      doReset();
      stepC(1, 2'b00);
      for (int k = 1; k <= 4; k++) begin
         stepC(0, 2'b01);
         checkValue("saturate_score", 32'(cScores[1:0]), (k < 3) ? 32'(k) : 32'd3);
         stepC(0, 2'b00);
         stepC(0, 2'b00);
      end
      checkValue("saturate_no_over", 32'(cOver), 32'd0);
      checkValue("saturate_running", 32'(cOn), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/match_controller.md
Name: match_controller

Overview:
- Parametrised successor of the top-level game timer/scoreboard.
- Owns the match state machine, the per-second countdown, per-team score counters, the win-score limit, the post-goal hold and optional sudden-death overtime.
- Sits between the ball controller, which supplies goal pulses, and the display/ball logic, which consume game_on, game_over and the scores.

Parameters:
- NUM_TEAMS, 2, number of teams (2..8).
- SCORE_W, 4, width of each score counter.
- TIME_W, 8, width of time_left.
- MATCH_SECONDS, 180, countdown start value (must fit TIME_W).
- TICKS_PER_SEC, 50000000, clk cycles per second.
- WIN_SCORE, 10, score that ends the match immediately; 0 disables the limit.
- HOLD_CYCLES, 25000000, clk cycles play is frozen after a goal; 0 means no hold.
- OVERTIME_EN, 1, on a draw at time 0: 1 enters sudden death, 0 ends the match.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, asynchronous active-high reset.
- start, input, 1, level; starts the match from IDLE.
- pause, input, 1, single-cycle pulse; toggles RUN/PAUSED.
- goal, input, NUM_TEAMS, bit i pulses one cycle when team i scores.
- game_on, output, 1, high in RUN and SUDDEN.
- game_over, output, 1, high in OVER.
- in_hold, output, 1, high in HOLD.
- overtime, output, 1, high in SUDDEN, and in OVER when entered from SUDDEN.
- sec_tick, output, 1, one-cycle pulse on each countdown decrement.
- time_left, output, TIME_W, seconds remaining.
- scores, output, NUM_TEAMS*SCORE_W, team i occupies bits [i*SCORE_W +: SCORE_W].
- winner, output, 3, index of the winning team, valid only with winner_valid.
- winner_valid, output, 1, high in OVER when exactly one team leads.

Behaviour:
- Reset (async, rst high):
  - state = IDLE.
  - time_left = MATCH_SECONDS.
  - All scores = 0.
  - Tick counter = 0.
  - Hold counter = 0.
  - All outputs low except time_left.
- States:
  - IDLE -> RUN when start = 1.
  - RUN: the tick counter increments every cycle. At TICKS_PER_SEC-1 the counter returns to 0, time_left decrements and sec_tick pulses.
  - RUN -> PAUSED on a pause pulse. The tick counter and time_left are held. Goals are ignored.
  - PAUSED -> RUN on a pause pulse.
  - RUN/SUDDEN -> HOLD on any goal bit, unless the goal ends the match (see below).
    - The hold counter loads HOLD_CYCLES-1.
    - If HOLD_CYCLES = 0, there is no HOLD and the state stays RUN/SUDDEN.
  - HOLD: the timer is frozen and goals are ignored. When the hold counter reaches 0, return to the state it was entered from.
  - When time_left becomes 0 in RUN, the transition is taken in the cycle after the decrement:
    - unique leader -> OVER;
    - draw and OVERTIME_EN = 1 -> SUDDEN;
    - otherwise -> OVER.
  - SUDDEN: no countdown. A goal cycle that leaves a unique leader -> OVER. Otherwise -> HOLD, then back to SUDDEN.
  - OVER is terminal until rst. Inputs are ignored.
- Goal accounting:
  - Every set goal bit in an accepted cycle increments its team, so simultaneous goals all count.
  - Counters saturate at 2^SCORE_W-1.
  - Pause and goal in the same cycle: the goal is counted and the pause is ignored.
- Win limit: with WIN_SCORE != 0, any post-increment score >= WIN_SCORE -> OVER in the next cycle, with precedence over HOLD.
  - If two teams reach the limit in the same cycle: winner_valid = 1 only if their scores differ.
- Timer expiry and a goal in the same cycle: the goal is counted first, then the expiry rule is evaluated on the updated scores.
- Leader logic: combinational max over the registered scores. winner = lowest index holding the max. winner_valid requires that max to be unique.
- All outputs are registered, except winner and winner_valid, which are decoded from registered state and scores.

Decomposition:
- Shared package game_pkg:
  - state enum {IDLE, RUN, PAUSED, HOLD, SUDDEN, OVER};
  - function clog2;
  - constant MAX_TEAMS = 8.
- Sub-module tick_divider(clk, rst, en, tick), parametrised by TICKS_PER_SEC. Used here, and reusable by the player and ball movement controllers.

Test Plan:
All tests use TICKS_PER_SEC=4, MATCH_SECONDS=3, HOLD_CYCLES=2, WIN_SCORE=3, NUM_TEAMS=2 unless stated.
1. Countdown: start=1, no goals, OVERTIME_EN=0 -> sec_tick every 4 cycles; time_left goes 3,2,1,0; OVER with winner_valid=0.
2. Hold and pause: a goal[0] pulse in RUN -> score0=1, in_hold for 2 cycles, timer frozen. A pause pulse then freezes time_left until a second pause pulse.
3. Win limit: three goal[1] pulses, each spaced after the hold -> score1=3, OVER next cycle, winner=1, winner_valid=1, time_left frozen.
4. Simultaneous goals: goal=2'b11 with both teams at 2 -> both scores reach 3, OVER, winner_valid=0.
5. Sudden death: OVERTIME_EN=1, 0:0 at expiry -> SUDDEN, overtime=1. A later goal[1] -> OVER, winner=1.
6. Async reset: assert rst mid-HOLD, between clock edges -> immediate IDLE, scores 0, time_left=3. Saturation check with SCORE_W=2, WIN_SCORE=0 -> a score stays at 3.
